// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and widths for the arbitrated shift-free multiplier
package mult_pkg;

    localparam int N_DEF    = 4;
    localparam int RESULT_W = 2 * N_DEF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/mult_seq.sv
// mult_seq: repeated-addition datapath (operand latch, accumulator, step counter)
import mult_pkg::*;

module mult_seq #(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           eq,
    output logic [2*N-1:0] acc
);

    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic [N-1:0] cnt;

    assign eq = cnt == b_reg;

    // load captures operands and clears the sum; step adds a once more
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            a_reg <= a_in;
            b_reg <= b_in;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            acc <= acc + {{N{1'b0}}, a_reg};
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mult_arb.sv
// mult_arb: two-requester round-robin front end driving a repeated-addition multiplier
import mult_pkg::*;

module mult_arb #(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [N-1:0]   a0,
    input  logic [N-1:0]   b0,
    input  logic           req1,
    input  logic [N-1:0]   a1,
    input  logic [N-1:0]   b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           busy,
    output logic           done,
    output logic           done_id,
    output logic [2*N-1:0] saida
);

    state_t         state;
    logic           last;
    logic           owner;
    logic           pick;
    logic           load;
    logic           step;
    logic           eq;
    logic [2*N-1:0] acc;

    // requester 1 wins a tie only if requester 0 was served last
    assign pick = (req0 && req1) ? !last : req1;
    assign load = (state == IDLE) && (req0 || req1);
    assign step = (state == RUN) && !eq;
    assign busy = state != IDLE;

    mult_seq #(.N(N)) u_seq (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .a_in (pick ? a1 : a0),
        .b_in (pick ? b1 : b0),
        .eq   (eq),
        .acc  (acc)
    );

    // control FSM with registered grant/done pulses and result hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            saida   <= '0;
            owner   <= 1'b0;
            last    <= 1'b1;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    gnt0  <= !pick;
                    gnt1  <= pick;
                    owner <= pick;
                    last  <= pick;
                    state <= RUN;
                end
                RUN: if (eq) state <= DONE;
                DONE: begin
                    saida   <= acc;
                    done    <= 1'b1;
                    done_id <= owner;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arb.sv
// tb_mult_arb: table, hand-written and randomized checks of mult_arb against a simple model
module tb_mult_arb;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req0 = 1'b0;
    logic           req1 = 1'b0;
    logic [N-1:0]   a0 = '0;
    logic [N-1:0]   b0 = '0;
    logic [N-1:0]   a1 = '0;
    logic [N-1:0]   b1 = '0;
    logic           gnt0;
    logic           gnt1;
    logic           busy;
    logic           done;
    logic           done_id;
    logic [2*N-1:0] saida;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit r0;
        int a0;
        int b0;
        bit r1;
        int a1;
        int b1;
        int id;
        int prod;
        int lat;
    } vec_t;

    mult_arb #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .saida   (saida)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_gnt(output int id, output int cyc, output bit both);
        id = -1;
        cyc = 0;
        both = 0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (gnt0 && gnt1) both = 1;
            if (gnt0 || gnt1) begin
                id = gnt1 ? 1 : 0;
                break;
            end
        end
    endtask

    task automatic wait_done(output int cyc, output bit stray, output bit idle_gap);
        cyc = 0;
        stray = 0;
        idle_gap = 0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (gnt0 || gnt1) stray = 1;
            if (done) break;
            if (!busy) idle_gap = 1;
        end
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        int id, gc, lat;
        bit both, stray, gap;
        req0 = v.r0;
        a0 = 4'(v.a0);
        b0 = 4'(v.b0);
        req1 = v.r1;
        a1 = 4'(v.a1);
        b1 = 4'(v.b1);
        wait_gnt(id, gc, both);
        chk({tag, " gnt_id"}, id, v.id);
        chk({tag, " gnt_delay"}, gc, 1);
        chk({tag, " gnt_exclusive"}, int'(both), 0);
        chk({tag, " busy_at_gnt"}, int'(busy), 1);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done(lat, stray, gap);
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " saida"}, int'(saida), v.prod);
        chk({tag, " done_id"}, int'(done_id), v.id);
        chk({tag, " no_gnt_while_busy"}, int'(stray), 0);
        chk({tag, " busy_throughout"}, int'(gap), 0);
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        int id, gc, lat, m_last, pat;
        bit both, stray, gap, seen;

        tbl[0] = '{1, 3, 5, 0, 0, 0, 0, 15, 7};
        tbl[1] = '{0, 0, 0, 1, 9, 0, 1, 0, 2};
        tbl[2] = '{1, 2, 2, 1, 4, 3, 0, 4, 4};
        tbl[3] = '{1, 7, 6, 1, 5, 4, 1, 20, 6};
        tbl[4] = '{1, 15, 15, 0, 0, 0, 0, 225, 17};
        tbl[5] = '{0, 0, 0, 1, 15, 1, 1, 15, 3};
        tbl[6] = '{1, 0, 3, 1, 1, 1, 0, 0, 5};
        tbl[7] = '{0, 0, 0, 1, 1, 15, 1, 15, 17};

        do_reset();
        chk("reset saida", int'(saida), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset gnt", int'({gnt0, gnt1}), 0);
        chk("reset done_id", int'(done_id), 0);

        for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

        // both held from reset: alternation with back-to-back grants
        do_reset();
        req0 = 1'b1; a0 = 4'd2; b0 = 4'd2;
        req1 = 1'b1; a1 = 4'd4; b1 = 4'd3;
        wait_gnt(id, gc, both);
        chk("rr first id", id, 0);
        chk("rr first delay", gc, 1);
        wait_done(lat, stray, gap);
        chk("rr first latency", lat, 4);
        chk("rr first saida", int'(saida), 4);
        wait_gnt(id, gc, both);
        chk("rr second id", id, 1);
        chk("rr second spacing", gc, 1);
        wait_done(lat, stray, gap);
        chk("rr second latency", lat, 5);
        chk("rr second saida", int'(saida), 12);
        chk("rr second done_id", int'(done_id), 1);
        wait_gnt(id, gc, both);
        chk("rr third id", id, 0);
        chk("rr third spacing", gc, 1);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done(lat, stray, gap);
        chk("rr third saida", int'(saida), 4);

        // reset mid-run aborts with no done pulse
        v = '{1, 3, 5, 0, 0, 0, 0, 15, 7};
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
        wait_gnt(id, gc, both);
        chk("abort gnt id", id, 0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort saida", int'(saida), 0);
        chk("abort done_id", int'(done_id), 0);
        chk("abort gnt", int'({gnt0, gnt1}), 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("abort no resume", int'(seen), 0);
        v = '{1, 1, 1, 0, 0, 0, 0, 1, 3};
        run_txn("after_abort", v);

        // randomized traffic against an arithmetic model with its own round-robin pointer
        m_last = 0;
        for (int k = 0; k < 40; k++) begin
            pat  = $urandom_range(1, 3);
            v.r0 = pat[0];
            v.r1 = pat[1];
            v.a0 = $urandom_range(0, 15);
            v.b0 = $urandom_range(0, 15);
            v.a1 = $urandom_range(0, 15);
            v.b1 = $urandom_range(0, 15);
            v.id = (v.r0 && v.r1) ? (m_last == 0 ? 1 : 0) : (v.r1 ? 1 : 0);
            v.prod = v.id ? v.a1 * v.b1 : v.a0 * v.b0;
            v.lat  = (v.id ? v.b1 : v.b0) + 2;
            run_txn($sformatf("rnd%0d", k), v);
            m_last = v.id;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
